// File: rtl/flash_pkg.sv
// Shared state encoding, bridge direction codes and defaults for the flash sequencer.
package flash_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic FB_DIR_READ  = 1'b1;
  localparam logic FB_DIR_WRITE = 1'b0;

  localparam logic [7:0] DEF_BASE_ADDR = 8'h00;

  // Flash byte address of buffer entry idx; wraps modulo 256.
  function automatic logic [7:0] flash_addr(input logic [7:0] base, input logic [5:0] idx);
    return base + {2'b00, idx};
  endfunction

endpackage

// File: rtl/flash_seq_if.sv
// Request/completion bus between the sequencer (master) and the flash bridge (slave).
interface flash_seq_if;

  logic [7:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       fb_dir;
  logic       fb_start;
  logic       fb_done;
  logic [7:0] fb_rdata;

  modport master (output fb_addr, output fb_wdata, output fb_dir, output fb_start,
                  input fb_done, input fb_rdata);
  modport slave  (input fb_addr, input fb_wdata, input fb_dir, input fb_start,
                  output fb_done, output fb_rdata);

endinterface

// File: rtl/flash_seq_buf.sv
// Score byte buffer: host and sequencer write ports (sequencer wins), two combinational read ports.
module flash_seq_buf #(
  parameter int NBYTES = 8
) (
  input  logic       CLK_50MHZ,
  input  logic       host_we,
  input  logic [5:0] host_widx,
  input  logic [7:0] host_wdata,
  input  logic [5:0] host_ridx,
  output logic [7:0] host_rdata,
  input  logic       seq_we,
  input  logic [5:0] seq_widx,
  input  logic [7:0] seq_wdata,
  input  logic [5:0] seq_ridx,
  output logic [7:0] seq_rdata
);

  localparam int         AW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [6:0] NB7 = 7'(NBYTES);

  logic [7:0] mem_r [2**AW];
  logic       host_wok_s;
  logic       seq_wok_s;

  assign host_wok_s = ({1'b0, host_widx} < NB7);
  assign seq_wok_s  = ({1'b0, seq_widx} < NB7);

  // Buffer storage; contents deliberately survive reset.
  always_ff @(posedge CLK_50MHZ) begin
    if (seq_we && seq_wok_s) begin
      mem_r[seq_widx[AW-1:0]] <= seq_wdata;
    end else if (host_we && host_wok_s) begin
      mem_r[host_widx[AW-1:0]] <= host_wdata;
    end
  end

  // Out-of-range indices read as zero instead of aliasing onto real entries.
  assign host_rdata = ({1'b0, host_ridx} < NB7) ? mem_r[host_ridx[AW-1:0]] : 8'h00;
  assign seq_rdata  = ({1'b0, seq_ridx} < NB7)  ? mem_r[seq_ridx[AW-1:0]]  : 8'h00;

endmodule

// File: rtl/flash_seq.sv
// Flash sequencer: streams the score buffer to/from the flash bridge one byte per handshake,
// with a one-cycle gap between bytes and a per-byte completion timeout.
module flash_seq
  import flash_pkg::*;
#(
  parameter int         NBYTES      = 8,
  parameter logic [7:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              save,
  input  logic              load,
  input  logic              wr_en,
  input  logic [5:0]        wr_idx,
  input  logic [7:0]        wr_data,
  input  logic [5:0]        rd_idx,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  flash_seq_if.master       fb
);

  localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [5:0]    IDX_LAST = 6'(NBYTES - 1);

  logic [2:0]    state_r, state_nxt_s;
  logic [5:0]    idx_r, idx_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [7:0]    fb_addr_r, fb_addr_nxt_s;
  logic [7:0]    fb_wdata_r, fb_wdata_nxt_s;
  logic          fb_dir_r, fb_dir_nxt_s;
  logic          fb_start_r, fb_start_nxt_s;
  logic          err_r, err_nxt_s;
  logic          seq_we_s;
  logic [7:0]    seq_rdata_s;
  logic          timeout_s;
  logic          last_s;

  assign timeout_s = (cnt_r == CNT_LAST);
  assign last_s    = (idx_r == IDX_LAST);

  flash_seq_buf #(.NBYTES(NBYTES)) u_buf (
    .CLK_50MHZ  (CLK_50MHZ),
    .host_we    (wr_en & ~busy),
    .host_widx  (wr_idx),
    .host_wdata (wr_data),
    .host_ridx  (rd_idx),
    .host_rdata (rd_data),
    .seq_we     (seq_we_s),
    .seq_widx   (idx_r),
    .seq_wdata  (fb.fb_rdata),
    .seq_ridx   (idx_r),
    .seq_rdata  (seq_rdata_s)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      idx_r      <= 6'd0;
      cnt_r      <= '0;
      fb_addr_r  <= 8'h00;
      fb_wdata_r <= 8'h00;
      fb_dir_r   <= FB_DIR_WRITE;
      fb_start_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      fb_addr_r  <= fb_addr_nxt_s;
      fb_wdata_r <= fb_wdata_nxt_s;
      fb_dir_r   <= fb_dir_nxt_s;
      fb_start_r <= fb_start_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (save || load) state_nxt_s = ST_ISSUE;
        else              state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (fb.fb_done)     state_nxt_s = ST_GAP;
        else if (timeout_s) state_nxt_s = ST_FINISH;
        else                state_nxt_s = ST_WAIT;
      end
      ST_GAP: begin
        if (last_s) state_nxt_s = ST_FINISH;
        else        state_nxt_s = ST_ISSUE;
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; save has priority over load.
  always_comb begin
    idx_nxt_s      = idx_r;
    cnt_nxt_s      = cnt_r;
    fb_addr_nxt_s  = fb_addr_r;
    fb_wdata_nxt_s = fb_wdata_r;
    fb_dir_nxt_s   = fb_dir_r;
    fb_start_nxt_s = fb_start_r;
    err_nxt_s      = err_r;
    seq_we_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (save) begin
          fb_dir_nxt_s = FB_DIR_WRITE;
          idx_nxt_s    = 6'd0;
          err_nxt_s    = 1'b0;
        end else if (load) begin
          fb_dir_nxt_s = FB_DIR_READ;
          idx_nxt_s    = 6'd0;
          err_nxt_s    = 1'b0;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_ISSUE: begin
        fb_addr_nxt_s  = flash_addr(BASE_ADDR, idx_r);
        fb_wdata_nxt_s = seq_rdata_s;
        fb_start_nxt_s = 1'b1;
        cnt_nxt_s      = '0;
      end
      ST_WAIT: begin
        if (fb.fb_done) begin
          seq_we_s       = (fb_dir_r == FB_DIR_READ);
          fb_start_nxt_s = 1'b0;
        end else if (timeout_s) begin
          fb_start_nxt_s = 1'b0;
          err_nxt_s      = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      ST_GAP: begin
        if (last_s) idx_nxt_s = idx_r;
        else        idx_nxt_s = idx_r + 6'd1;
      end
      ST_FINISH: fb_start_nxt_s = 1'b0;
      default:   fb_start_nxt_s = 1'b0;
    endcase
  end

  assign busy        = (state_r != ST_IDLE);
  assign done        = (state_r == ST_FINISH);
  assign err         = err_r;
  assign fb.fb_addr  = fb_addr_r;
  assign fb.fb_wdata = fb_wdata_r;
  assign fb.fb_dir   = fb_dir_r;
  // The request is withdrawn in the same cycle RST rises, not one edge later.
  assign fb.fb_start = fb_start_r & ~RST;

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: bridge models plus a scoreboard of expected bridge transactions.
module tb_flash_seq;
  import flash_pkg::*;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       dir;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST, save, load, wr_en;
  logic [5:0] wr_idx, rd_idx;
  logic [7:0] wr_data, rd_data, w_rd_data;
  logic       busy, done, err, w_busy, w_done, w_err;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  exp_t       m_e;
  logic [7:0] model_buf [8];

  flash_seq_if bif ();
  flash_seq_if wif ();

  flash_seq #(.NBYTES(8), .BASE_ADDR(8'h00), .TIMEOUT_CYC(1023)) dut (
    .CLK_50MHZ(CLK), .RST(RST), .save(save), .load(load), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .fb(bif));

  flash_seq #(.NBYTES(8), .BASE_ADDR(8'hFC), .TIMEOUT_CYC(1023)) u_wrap (
    .CLK_50MHZ(CLK), .RST(RST), .save(save), .load(load), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(w_rd_data),
    .busy(w_busy), .done(w_done), .err(w_err), .fb(wif));

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main bridge: fb_done on the 5th cycle of fb_start, except byte 2 when stalled.
  int   lat_cnt = 0, starts = 0, last_high_len = 0, done_cnt = 0;
  bit   stall = 1'b0;
  logic prev_start = 1'b0, prev_done = 1'b0;
  always @(negedge CLK) begin
    if (prev_done) chk("gap_low", 32'(bif.fb_start), 32'(0));
    prev_done   = 1'b0;
    bif.fb_done = 1'b0;
    if (done === 1'b1) done_cnt++;
    if (bif.fb_start === 1'b1) begin
      if (!prev_start) begin
        starts++;
        lat_cnt = 0;
      end
      lat_cnt++;
      if (lat_cnt == 5 && !(stall && bif.fb_addr == 8'd2)) begin
        bif.fb_done  = 1'b1;
        bif.fb_rdata = 8'hA0 + bif.fb_addr;
        prev_done    = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed addr %0h, expected no transaction", bif.fb_addr);
        end else begin
          m_e = sb.pop_front();
          chk("fb_addr", 32'(bif.fb_addr), 32'(m_e.addr));
          chk("fb_wdata", 32'(bif.fb_wdata), 32'(m_e.data));
          chk("fb_dir", 32'(bif.fb_dir), 32'(m_e.dir));
        end
      end
    end else if (prev_start) begin
      last_high_len = lat_cnt;
    end
    prev_start = (bif.fb_start === 1'b1);
  end

  // Wrap-around instance bridge: answers on the 3rd cycle and logs addresses.
  int         w_cnt = 0, w_done_cnt = 0;
  logic [7:0] w_addrs[$];
  always @(negedge CLK) begin
    wif.fb_done  = 1'b0;
    wif.fb_rdata = 8'h00;
    if (w_done === 1'b1) w_done_cnt++;
    if (wif.fb_start === 1'b1) begin
      w_cnt++;
      if (w_cnt == 3) begin
        wif.fb_done = 1'b1;
        w_addrs.push_back(wif.fb_addr);
      end
    end else begin
      w_cnt = 0;
    end
  end

  task automatic host_wr(input logic [5:0] idx, input logic [7:0] data);
    @(posedge CLK); #1;
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse(input logic s, input logic l);
    @(posedge CLK); #1;
    save = s; load = l;
    @(posedge CLK); #1;
    save = 1'b0; load = 1'b0;
  endtask

  task automatic push_xfer(input logic dir, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{8'(i), model_buf[i], dir});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(n < budget), 32'(1));
  endtask

  int s0, d0;

  initial begin
    RST = 1'b1; save = 1'b0; load = 1'b0; wr_en = 1'b0;
    wr_idx = 6'd0; wr_data = 8'h00; rd_idx = 6'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_start", 32'(bif.fb_start), 32'(0));
    chk("rst_dir", 32'(bif.fb_dir), 32'(0));
    chk("rst_addr", 32'(bif.fb_addr), 32'(0));
    chk("rst_wdata", 32'(bif.fb_wdata), 32'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    // Host buffer access: fill, out-of-range, same-cycle write/read.
    for (int i = 0; i < 7; i++) begin
      host_wr(6'(i), 8'h10 + 8'(i));
      model_buf[i] = 8'h10 + 8'(i);
    end
    host_wr(6'd7, 8'h5A);
    host_wr(6'd9, 8'h55);
    rd_chk("rd_oob", 6'd9, 8'h00);
    rd_chk("rd_alias", 6'd1, 8'h11);
    @(posedge CLK); #1;
    wr_en = 1'b1; wr_idx = 6'd7; wr_data = 8'h17; rd_idx = 6'd7;
    #1;
    chk("rd_old", 32'(rd_data), 32'(8'h5A));
    @(posedge CLK); #1;
    wr_en = 1'b0;
    chk("rd_new", 32'(rd_data), 32'(8'h17));
    model_buf[7] = 8'h17;

    // Save of the whole buffer.
    push_xfer(FB_DIR_WRITE, 8);
    s0 = starts; d0 = done_cnt;
    pulse(1'b1, 1'b0);
    chk("save_busy", 32'(busy), 32'(1));
    wait_done("save_done", 500);
    @(negedge CLK);
    chk("save_pulse1", 32'(done), 32'(0));
    chk("save_done_cnt", 32'(done_cnt - d0), 32'(1));
    chk("save_starts", 32'(starts - s0), 32'(8));
    chk("save_sb_empty", 32'(sb.size()), 32'(0));
    chk("save_idle", 32'(busy), 32'(0));
    chk("wrap_count", 32'(w_addrs.size()), 32'(8));
    for (int i = 0; i < 8 && i < w_addrs.size(); i++) begin
      logic [7:0] ea;
      ea = 8'hFC + 8'(i);
      chk("wrap_addr", 32'(w_addrs[i]), 32'(ea));
    end
    chk("wrap_done", 32'(w_done_cnt), 32'(1));
    chk("wrap_idle", 32'({w_busy, w_err}), 32'(0));

    // Load: bridge returns 0xA0 + addr.
    push_xfer(FB_DIR_READ, 8);
    pulse(1'b0, 1'b1);
    wait_done("load_done", 500);
    @(negedge CLK);
    for (int i = 0; i < 8; i++) model_buf[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 8; i++) rd_chk("load_buf", 6'(i), model_buf[i]);
    chk("load_err", 32'(err), 32'(0));
    chk("load_sb_empty", 32'(sb.size()), 32'(0));

    // Timeout on byte 2.
    stall = 1'b1;
    push_xfer(FB_DIR_WRITE, 2);
    s0 = starts; d0 = done_cnt;
    pulse(1'b1, 1'b0);
    wait_done("to_done", 3000);
    @(negedge CLK);
    @(negedge CLK);
    chk("to_err", 32'(err), 32'(1));
    chk("to_start_low", 32'(bif.fb_start), 32'(0));
    chk("to_wait_len", 32'(last_high_len), 32'(1023));
    chk("to_starts", 32'(starts - s0), 32'(3));
    chk("to_done_cnt", 32'(done_cnt - d0), 32'(1));
    chk("to_sb_empty", 32'(sb.size()), 32'(0));
    stall = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("err_sticky", 32'(err), 32'(1));

    // save+load together, then save and a host write while busy.
    push_xfer(FB_DIR_WRITE, 8);
    s0 = starts; d0 = done_cnt;
    pulse(1'b1, 1'b1);
    chk("both_err_clr", 32'(err), 32'(0));
    repeat (10) @(posedge CLK);
    pulse(1'b1, 1'b0);
    host_wr(6'd0, 8'hEE);
    wait_done("both_done", 500);
    repeat (20) @(negedge CLK);
    chk("both_starts", 32'(starts - s0), 32'(8));
    chk("both_done_cnt", 32'(done_cnt - d0), 32'(1));
    chk("both_idle", 32'(busy), 32'(0));
    chk("both_sb_empty", 32'(sb.size()), 32'(0));
    rd_chk("busy_wr_ignored", 6'd0, model_buf[0]);

    // RST during WAIT of byte 4, then a fresh save from address 0.
    push_xfer(FB_DIR_WRITE, 8);
    s0 = starts;
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (starts >= s0 + 5) break;
    end
    chk("rst_reach_b4", 32'(starts - s0), 32'(5));
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("rst_start_now", 32'(bif.fb_start), 32'(0));
    @(posedge CLK); #1;
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_done", 32'(done), 32'(0));
    chk("rst_mid_start", 32'(bif.fb_start), 32'(0));
    chk("rst_mid_addr", 32'(bif.fb_addr), 32'(0));
    chk("rst_sb_left", 32'(sb.size()), 32'(4));
    sb.delete();
    RST = 1'b0;
    push_xfer(FB_DIR_WRITE, 8);
    s0 = starts;
    pulse(1'b1, 1'b0);
    wait_done("rst_resave_done", 500);
    @(negedge CLK);
    chk("rst_resave_starts", 32'(starts - s0), 32'(8));
    chk("rst_resave_sb", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
